rand_int_arbiter: RTL and testbench

Shares one 32-bit noise generator among `N_REQ` neuron requesters. Each requester presents a base integer; the block arbitrates, advances the generator exactly once per grant, and returns the base with its low `NOISE_BITS` replaced by fresh random bits, tagged with the requester id. It sits between the neuron array and synapse/input-current logic running on `neuron_clk`. Because the generator advances only on grants, sequences are deterministic for a given request pattern.

---
 rtl/rand_int_arbiter.sv | 138 +++++++++++++
 tb/tb_rand_int_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rand_int_arbiter.sv
// Shares one 32-bit Galois LFSR among N_REQ requesters; each grant draws fresh noise bits into the low bits of that requester's base word.
// Optional macro RAND_ARB_FIXED_PRIO_EN selects fixed (lowest index wins) priority instead of round-robin.
module rand_int_arbiter #(
  parameter int          N_REQ      = 4,
  parameter int          NOISE_BITS = 10,
  parameter logic [31:0] SEED       = 32'h5EED1234
) (
  input  logic               neuron_clk,
  input  logic               reset_global_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [32*N_REQ-1:0] i_in,
  output logic [N_REQ-1:0]   gnt,
  output logic [31:0]        i_rand_out,
  output logic               out_valid,
  output logic [3:0]         out_id,
  output logic               busy
);

  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] TAPS     = 32'hA3000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        lfsr_q, lfsr_next;
  logic [31:0]        base_q;
  logic [3:0]         id_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [31:0]        i_rand_out_q;
  logic               out_valid_q;
  logic [3:0]         out_id_q;

  logic               win_found;
  logic [3:0]         win_id;
  logic [31:0]        win_base;
  logic [N_REQ-1:0]   win_onehot;

`ifndef RAND_ARB_FIXED_PRIO_EN
  logic [3:0]         last_grant_q;
`endif

  assign lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);

  // Winner search. Round-robin runs two passes: first the requesters above
  // last_grant, then wraps to the lowest asserted index.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    win_found  = 1'b0;
    win_id     = 4'd0;
    win_base   = 32'h0;
    win_onehot = '0;
`ifndef RAND_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && req[i] && (4'(i) > last_grant_q)) begin
        win_found     = 1'b1;
        win_id        = 4'(i);
        win_base      = i_in[32*i +: 32];
        win_onehot[i] = 1'b1;
      end
    end
`endif
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && req[i]) begin
        win_found     = 1'b1;
        win_id        = 4'(i);
        win_base      = i_in[32*i +: 32];
        win_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (win_found) state_d = DRAW;
      DRAW:    state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge neuron_clk or negedge reset_global_n) begin
    if (!reset_global_n) state_q <= IDLE;
    else                 state_q <= state_d;
  end

  // Datapath. The LFSR moves only at the DRAW edge, so idle time never
  // perturbs the noise sequence.
  always_ff @(posedge neuron_clk or negedge reset_global_n) begin
    if (!reset_global_n) begin
      lfsr_q       <= SEED_EFF;
      base_q       <= 32'h0;
      id_q         <= 4'd0;
      gnt_q        <= '0;
      i_rand_out_q <= 32'h0;
      out_valid_q  <= 1'b0;
      out_id_q     <= 4'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      gnt_q       <= '0;
      out_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (win_found) begin
            gnt_q  <= win_onehot;
            base_q <= win_base;
            id_q   <= win_id;
          end
        end
        DRAW: begin
          lfsr_q       <= lfsr_next;
          i_rand_out_q <= {base_q[31:NOISE_BITS], lfsr_next[NOISE_BITS-1:0]};
          out_valid_q  <= 1'b1;
          out_id_q     <= id_q;
        end
        default: ;
      endcase
    end
  end

`ifndef RAND_ARB_FIXED_PRIO_EN
  always_ff @(posedge neuron_clk or negedge reset_global_n) begin
    if (!reset_global_n)                    last_grant_q <= 4'(N_REQ - 1);
    else if (state_q == IDLE && win_found)  last_grant_q <= win_id;
  end
`endif

  assign gnt        = gnt_q;
  assign i_rand_out = i_rand_out_q;
  assign out_valid  = out_valid_q;
  assign out_id     = out_id_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rand_int_arbiter.sv
// Directed self-checking bench for rand_int_arbiter (N_REQ=4, NOISE_BITS=10, default SEED).
// Define RAND_ARB_FIXED_PRIO_EN for both files to exercise the fixed-priority build.
module tb_rand_int_arbiter;

  logic         neuron_clk;
  logic         reset_global_n;
  logic [3:0]   req;
  logic [127:0] i_in;
  logic [3:0]   gnt;
  logic [31:0]  i_rand_out;
  logic         out_valid;
  logic [3:0]   out_id;
  logic         busy;

  int tests_run    = 0;
  int tests_failed = 0;

  rand_int_arbiter #(
    .N_REQ      (4),
    .NOISE_BITS (10),
    .SEED       (32'h5EED1234)
  ) dut (
    .neuron_clk     (neuron_clk),
    .reset_global_n (reset_global_n),
    .req            (req),
    .i_in           (i_in),
    .gnt            (gnt),
    .i_rand_out     (i_rand_out),
    .out_valid      (out_valid),
    .out_id         (out_id),
    .busy           (busy)
  );

  initial neuron_clk = 1'b0;
  always #5 neuron_clk = ~neuron_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge neuron_clk);
    #1;
  endtask

  task automatic do_reset();
    reset_global_n = 1'b0;
    req            = 4'b0000;
    tick();
    tick();
    reset_global_n = 1'b1;
  endtask

  function automatic logic [31:0] compose(input logic [31:0] base, input logic [9:0] noise);
    return {base[31:10], noise};
  endfunction

  // Low 10 bits of successive LFSR states from SEED:
  // 2F76891A, 17BB448D, A8DDA246, 546ED123, 89376891, E79B3448
  logic [9:0]  noise [6];
  logic [31:0] words [4];
  int          exp_ids [5];
  logic        seen;

  initial begin
    noise = '{10'h11A, 10'h08D, 10'h246, 10'h123, 10'h091, 10'h048};
    words = '{32'hFFFFFFFF, 32'h00000000, 32'h13579BDF, 32'h80000400};
`ifdef RAND_ARB_FIXED_PRIO_EN
    exp_ids = '{0, 0, 0, 0, 0};
`else
    exp_ids = '{0, 1, 2, 3, 0};
`endif
    reset_global_n = 1'b0;
    req            = 4'b0000;
    i_in           = '0;
    #2;

    // Reset state
    check("rst_gnt",       {28'h0, gnt}, 32'h0);
    check("rst_rand",      i_rand_out,   32'h0);
    check("rst_valid",     {31'h0, out_valid}, 32'h0);
    check("rst_id",        {28'h0, out_id},    32'h0);
    check("rst_busy",      {31'h0, busy},      32'h0);

    // Single requester 0
    do_reset();
    i_in[31:0] = 32'h12345678;
    req        = 4'b0001;
    tick();
    check("single_gnt",    {28'h0, gnt}, 32'h1);
    check("single_busy",   {31'h0, busy}, 32'h1);
    check("single_novalid",{31'h0, out_valid}, 32'h0);
    req = 4'b0000;
    tick();
    check("single_gnt_off",{28'h0, gnt}, 32'h0);
    check("single_valid",  {31'h0, out_valid}, 32'h1);
    check("single_id",     {28'h0, out_id}, 32'h0);
    check("single_rand",   i_rand_out, 32'h1234551A);
    tick();
    check("single_valid_off", {31'h0, out_valid}, 32'h0);
    check("single_hold",   i_rand_out, 32'h1234551A);
    tick();
    check("single_idle",   {31'h0, busy}, 32'h0);

    // All four requests held continuously
    do_reset();
    i_in = {words[3], words[2], words[1], words[0]};
    req  = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      check($sformatf("all_gnt%0d", g), {28'h0, gnt}, 32'(1) << exp_ids[g]);
      tick();
      check($sformatf("all_valid%0d", g), {31'h0, out_valid}, 32'h1);
      check($sformatf("all_id%0d", g), {28'h0, out_id}, 32'(exp_ids[g]));
      check($sformatf("all_rand%0d", g), i_rand_out, compose(words[exp_ids[g]], noise[g]));
      tick();
      check($sformatf("all_valid_off%0d", g), {31'h0, out_valid}, 32'h0);
    end
`ifdef RAND_ARB_FIXED_PRIO_EN
    req = 4'b1110;
    tick();
    check("fixed_gnt1",  {28'h0, gnt}, 32'h2);
    tick();
    check("fixed_rand1", i_rand_out, compose(words[1], noise[5]));
    tick();
`endif
    req = 4'b0000;
    tick();

    // Requester 2 drops during requester 1's draw; requester 1's base changes after grant
    do_reset();
    i_in = {32'h0, 32'h22222222, 32'h11111111, 32'h0};
    req  = 4'b0110;
    tick();
    check("drop_gnt1", {28'h0, gnt}, 32'h2);
    req          = 4'b0000;
    i_in[63:32]  = 32'hDEADBEEF;
    tick();
    check("drop_id",   {28'h0, out_id}, 32'h1);
    check("drop_rand", i_rand_out, 32'h1111111A);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (gnt != 4'b0000) seen = 1'b1;
    end
    check("drop_no_gnt2", {31'h0, seen}, 32'h0);

    // Reset asserted in DRAW
    do_reset();
    i_in = {96'h0, 32'h12345678};
    req  = 4'b0001;
    tick();
    check("rstdraw_gnt", {28'h0, gnt}, 32'h1);
    req            = 4'b0000;
    reset_global_n = 1'b0;
    #1;
    check("rstdraw_gnt0",   {28'h0, gnt},       32'h0);
    check("rstdraw_busy0",  {31'h0, busy},      32'h0);
    check("rstdraw_valid0", {31'h0, out_valid}, 32'h0);
    check("rstdraw_rand0",  i_rand_out,         32'h0);
    tick();
    reset_global_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("rstdraw_no_valid", {31'h0, seen}, 32'h0);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    check("rstdraw_valid", {31'h0, out_valid}, 32'h1);
    check("rstdraw_rand",  i_rand_out, 32'h1234551A);
    tick();
    tick();

    // Long idle does not advance the LFSR
    do_reset();
    repeat (100) tick();
    check("idle_busy", {31'h0, busy}, 32'h0);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    check("idle_valid", {31'h0, out_valid}, 32'h1);
    check("idle_rand",  i_rand_out, 32'h1234551A);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
